// File: rtl/mul_pkg.sv
// mul_pkg: shared control-state encoding and operand-width limits for the arithmetic blocks
package mul_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/shift_add_datapath.sv
// shift_add_datapath: operand magnitude registers, bit counter and shift-add accumulator
module shift_add_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mag_a,
    input  logic [WIDTH-1:0]   i_mag_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] w_pp;
    assign w_pp   = r_mag_b[r_count] ? ({{WIDTH{1'b0}}, r_mag_a} << r_count) : '0;
    assign o_acc  = r_acc;
    assign o_last = r_count == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_mag_a <= i_mag_a;
            r_mag_b <= i_mag_b;
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_step) begin
            r_acc   <= r_acc + w_pp;
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/seq_multiplier_nxn.sv
// seq_multiplier_nxn: WIDTH x WIDTH shift-add multiplier, signed or unsigned per operation
module seq_multiplier_nxn
    import mul_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    state_t             r_state;
    state_t             w_next;
    logic               r_neg;
    logic               r_done;
    logic [2*WIDTH-1:0] r_result;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc;
    function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic sg);
        return (sg && v[WIDTH-1]) ? -v : v;
    endfunction
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction
    shift_add_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_mag_a (abs_op(op_a, is_signed)),
        .i_mag_b (abs_op(op_b, is_signed)),
        .o_acc   (w_acc),
        .o_last  (w_last)
    );
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = start;
                w_next = start ? CALC : IDLE;
            end
            CALC: begin
                w_step = 1'b1;
                w_next = w_last ? FIX : CALC;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= r_state == FIX;
            if (w_load) r_neg <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            if (r_state == FIX) r_result <= apply_sign(w_acc, r_neg);
        end
    end
    assign busy   = r_state != IDLE;
    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_seq_multiplier_nxn.sv
// tb_seq_multiplier_nxn: directed checks of the 8-bit and 4-bit multiplier instances
module tb_seq_multiplier_nxn;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] res8;
    logic        s4 = 1'b0, sg4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  res4;
    int          checks = 0;
    int          errors = 0;
    int          n;
    int          bc;
    logic        seen;

    always #5 clk = ~clk;

    seq_multiplier_nxn #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .is_signed(sg8), .op_a(a8), .op_b(b8),
        .busy(busy8), .done(done8), .result(res8)
    );
    seq_multiplier_nxn #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(s4), .is_signed(sg4), .op_a(a4), .op_b(b4),
        .busy(busy4), .done(done4), .result(res4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait8(output int cyc, output int bsy);
        cyc = 0;
        bsy = int'(busy8);
        while (!done8 && cyc < 30) begin
            step;
            cyc++;
            bsy += int'(busy8);
        end
        chk("done8_seen", done8, 1);
    endtask

    task automatic op8(input string tag, input logic sg, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
        sg8 = sg; a8 = a; b8 = b; s8 = 1'b1;
        step;
        s8 = 1'b0;
        wait8(n, bc);
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_busy_cycles"}, bc, 9);
        chk({tag, "_result"}, res8, exp);
        step;
        chk({tag, "_done_pulse"}, done8, 0);
        chk({tag, "_hold"}, res8, exp);
    endtask

    task automatic op4(input string tag, input logic sg, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp);
        sg4 = sg; a4 = a; b4 = b; s4 = 1'b1;
        step;
        s4 = 1'b0;
        n = 0;
        bc = int'(busy4);
        while (!done4 && n < 30) begin
            step;
            n++;
            bc += int'(busy4);
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_busy_cycles"}, bc, 5);
        chk({tag, "_result"}, res4, exp);
        step;
        chk({tag, "_done_pulse"}, done4, 0);
    endtask

    initial begin
        s8 = 1'b1; s4 = 1'b1;
        repeat (3) step;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_res8", res8, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_res4", res4, 0);
        s8 = 1'b0; s4 = 1'b0;
        #2 reset = 1'b0;
        step;
        chk("idle_after_rst", busy8, 0);

        op8("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        op8("s_0xm7", 1'b1, 8'h00, 8'hF9, 16'h0000);
        op8("s_127xm128", 1'b1, 8'h7F, 8'h80, 16'hC080);
        op8("u_255x2", 1'b0, 8'hFF, 8'h02, 16'h01FE);
        op8("s_m1x2", 1'b1, 8'hFF, 8'h02, 16'hFFFE);

        // start held high: each done cycle must accept the next operands
        sg8 = 1'b0; a8 = 8'd10; b8 = 8'd20; s8 = 1'b1;
        step;
        sg8 = 1'b1; a8 = 8'hFD; b8 = 8'h05;
        wait8(n, bc);
        chk("b2b_res1", res8, 16'd200);
        chk("b2b_idle_in_done", busy8, 0);
        step;
        chk("b2b_accept2", busy8, 1);
        a8 = 8'd12; b8 = 8'hF4;
        wait8(n, bc);
        chk("b2b_res2", res8, 16'hFFF1);
        step;
        chk("b2b_accept3", busy8, 1);
        s8 = 1'b0;
        wait8(n, bc);
        chk("b2b_res3", res8, 16'hFF70);
        step;

        // start and operand changes mid-CALC must not disturb the operation
        sg8 = 1'b0; a8 = 8'd100; b8 = 8'd3; s8 = 1'b1;
        step;
        s8 = 1'b0;
        repeat (3) step;
        s8 = 1'b1; sg8 = 1'b1; a8 = 8'hFF; b8 = 8'h7F;
        step;
        s8 = 1'b0;
        wait8(n, bc);
        chk("midcalc_result", res8, 16'h012C);
        step;

        // reset in the middle of CALC aborts without a done pulse
        sg8 = 1'b0; a8 = 8'd7; b8 = 8'd9; s8 = 1'b1;
        step;
        s8 = 1'b0;
        repeat (4) step;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_result", res8, 0);
        chk("abort_done", done8, 0);
        #2 reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            step;
            seen |= done8;
        end
        chk("abort_no_done", seen, 0);
        op8("after_abort", 1'b0, 8'd6, 8'd7, 16'd42);

        op4("w4_s7xm8", 1'b1, 4'h7, 4'h8, 8'hC8);
        op4("w4_u15x15", 1'b0, 4'hF, 4'hF, 8'hE1);
        op4("w4_sm1xm1", 1'b1, 4'hF, 4'hF, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
